iob_pcie_loopback: RTL and testbench

IOB_PCIE_LOOPBACK -- requirements
Module: iob_pcie_loopback

---
 rtl/iob_pcie_pkg.sv | 28 ++
 rtl/iob_pcie_sfifo.sv | 71 +++++++
 rtl/iob_pcie_loopback.sv | 217 +++++++++++++++++++++
 tb/tb_iob_pcie_loopback.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_pcie_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_pcie_pkg
// Description : Shared definitions for the PCIe channel loopback block.
//               Holds the loopback FSM state encodings, the channel word
//               width and the helper that derives words-per-beat from the
//               channel data width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package iob_pcie_pkg;

    // The channel length/offset fields always count 32-bit words.
    localparam int unsigned c_word_w = 32;

    // Loopback FSM states.
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_rx   = 2'd1;
    localparam logic [1:0] c_st_turn = 2'd2;
    localparam logic [1:0] c_st_tx   = 2'd3;

    // Number of 32-bit words carried by one data beat.
    function automatic int unsigned words_per_beat(input int unsigned data_w);
        return data_w / c_word_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_pcie_sfifo.sv
`default_nettype none
// ============================================================================
// Module      : iob_pcie_sfifo
// Description : Single-clock first-word-fall-through FIFO, DATA_W bits wide
//               and 2^ADDR_W entries deep. The head entry is always visible
//               on o_rd_data while the FIFO is not empty; i_rd_en pops it.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_wr_en, i_wr_data - push (ignored while full)
//               i_rd_en            - pop (ignored while empty)
//               o_rd_data          - head-of-queue data
//               o_full, o_empty    - status flags
//               o_level            - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module iob_pcie_sfifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level
);

    localparam int c_depth = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_depth];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    assign w_push = i_wr_en & ~o_full;
    assign w_pop  = i_rd_en & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: resetting the pointers makes old contents
    // unreachable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                       (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign o_level   = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/iob_pcie_loopback.sv
`default_nettype none
// ============================================================================
// Module      : iob_pcie_loopback
// Description : PCIe channel loopback. Receives one RX transfer into a
//               buffer, then sends one TX transfer back, either echoing the
//               buffered beats (MODE=0) or a word-counter pattern (MODE=1).
//               Sequence: IDLE -> RX -> TURN -> TX -> IDLE.
// Ports       : CLK, RST            - clock, synchronous active-high reset
//               MODE                - 0 echo, 1 counter pattern
//               CNT_ERR             - sticky buffer-overflow flag
//               CHNL_RX_*           - receive channel (CHNL_RX_CLK = CLK)
//               CHNL_TX_*           - transmit channel (CHNL_TX_CLK = CLK)
// Revision    : 1.0 - initial release
// ============================================================================
module iob_pcie_loopback
    import iob_pcie_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MODE,
    output logic              CNT_ERR,
    // receive channel
    output logic              CHNL_RX_CLK,
    input  logic              CHNL_RX,
    output logic              CHNL_RX_ACK,
    input  logic              CHNL_RX_LAST,
    input  logic [31:0]       CHNL_RX_LEN,
    input  logic [30:0]       CHNL_RX_OFF,
    input  logic [DATA_W-1:0] CHNL_RX_DATA,
    input  logic              CHNL_RX_DATA_VALID,
    output logic              CHNL_RX_DATA_REN,
    // transmit channel
    output logic              CHNL_TX_CLK,
    output logic              CHNL_TX,
    input  logic              CHNL_TX_ACK,
    output logic              CHNL_TX_LAST,
    output logic [31:0]       CHNL_TX_LEN,
    output logic [30:0]       CHNL_TX_OFF,
    output logic [DATA_W-1:0] CHNL_TX_DATA,
    output logic              CHNL_TX_DATA_VALID,
    input  logic              CHNL_TX_DATA_REN
);

    localparam int unsigned c_w      = words_per_beat(DATA_W);
    localparam int unsigned c_log2w  = $clog2(c_w);
    // Buffer capacity in words; 34 bits so large ADDR_W cannot overflow.
    localparam logic [33:0] c_cap_words = 34'(c_w) << ADDR_W;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [31:0] r_len;        // requested RX length in words
    logic        r_mode;
    logic [31:0] r_word_cnt;   // words received so far (saturating)
    logic [31:0] r_tx_beat;    // beats sent so far
    logic        r_cnt_err;

    // ------------------------------------------------------------------
    // Buffer
    // ------------------------------------------------------------------
    logic              w_fifo_wr;
    logic              w_fifo_rd;
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [ADDR_W:0]   w_fifo_level;

    iob_pcie_sfifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk       (CLK),
        .rst       (RST),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (CHNL_RX_DATA),
        .i_rd_en   (w_fifo_rd),
        .o_rd_data (w_fifo_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_level   (w_fifo_level)
    );

    // ------------------------------------------------------------------
    // RX side
    // ------------------------------------------------------------------
    logic        w_in_rx;
    logic        w_rx_done;
    logic        w_rx_beat;
    logic [32:0] w_cnt_sum;
    logic [31:0] w_cnt_next;

    assign w_in_rx   = (r_state == c_st_rx);
    // Once enough words have arrived, further beats are not taken.
    assign w_rx_done = (r_word_cnt >= r_len);
    assign w_rx_beat = w_in_rx & ~w_rx_done & CHNL_RX_DATA_VALID;
    assign w_fifo_wr = w_rx_beat & ~w_fifo_full;

    assign w_cnt_sum  = {1'b0, r_word_cnt} + 33'(c_w);
    assign w_cnt_next = w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];

    // ------------------------------------------------------------------
    // TX length: min(requested, capacity) rounded up to whole beats
    // ------------------------------------------------------------------
    logic [33:0] w_len_ext;
    logic [33:0] w_len_min;
    logic [33:0] w_len_rnd;
    logic [31:0] w_tx_len;
    logic [31:0] w_tx_beats;

    assign w_len_ext  = {2'b00, r_len};
    assign w_len_min  = (w_len_ext < c_cap_words) ? w_len_ext : c_cap_words;
    assign w_len_rnd  = ((w_len_min + 34'(c_w - 1)) >> c_log2w) << c_log2w;
    assign w_tx_len   = w_len_rnd[31:0];
    assign w_tx_beats = w_tx_len >> c_log2w;

    // ------------------------------------------------------------------
    // TX side
    // ------------------------------------------------------------------
    logic              w_in_tx;
    logic              w_tx_more;
    logic              w_tx_ready;
    logic              w_tx_valid;
    logic              w_tx_xfer;
    logic [31:0]       w_pat_base;
    logic [DATA_W-1:0] w_pattern;

    assign w_in_tx    = (r_state == c_st_tx);
    assign w_tx_more  = (r_tx_beat != w_tx_beats);
    // The pattern generator is always ready; echo waits on buffered data.
    assign w_tx_ready = r_mode | (w_fifo_level != '0);
    assign w_tx_valid = w_in_tx & w_tx_more & w_tx_ready;
    assign w_tx_xfer  = w_tx_valid & CHNL_TX_DATA_REN;
    // The buffer drains in pattern mode too, so it is empty when TX ends.
    assign w_fifo_rd  = w_tx_xfer & ~w_fifo_empty;

    // Beat k word j carries k*W + j + 1.
    assign w_pat_base = r_tx_beat << c_log2w;

    for (genvar gi = 0; gi < int'(c_w); gi++) begin : g_pat
        assign w_pattern[gi*32 +: 32] = w_pat_base + 32'(gi + 1);
    end

    // ------------------------------------------------------------------
    // FSM and counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= c_st_idle;
            r_len      <= '0;
            r_mode     <= 1'b0;
            r_word_cnt <= '0;
            r_tx_beat  <= '0;
            r_cnt_err  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (CHNL_RX) begin
                        r_len      <= CHNL_RX_LEN;
                        r_mode     <= MODE;
                        r_word_cnt <= '0;
                        r_tx_beat  <= '0;
                        r_cnt_err  <= 1'b0;
                        r_state    <= c_st_rx;
                    end
                end
                c_st_rx: begin
                    if (w_rx_done) begin
                        r_state <= c_st_turn;
                    end else if (w_rx_beat) begin
                        r_word_cnt <= w_cnt_next;
                        if (w_fifo_full) begin
                            r_cnt_err <= 1'b1;
                        end
                    end
                end
                c_st_turn: begin
                    r_state <= (r_len == '0) ? c_st_idle : c_st_tx;
                end
                c_st_tx: begin
                    if (w_tx_xfer) begin
                        r_tx_beat <= r_tx_beat + 32'd1;
                        if (r_tx_beat + 32'd1 == w_tx_beats) begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign CHNL_RX_CLK        = CLK;
    assign CHNL_TX_CLK        = CLK;
    assign CHNL_RX_ACK        = w_in_rx;
    assign CHNL_RX_DATA_REN   = w_in_rx;
    assign CHNL_TX            = w_in_tx;
    assign CHNL_TX_LAST       = 1'b1;
    assign CHNL_TX_OFF        = '0;
    assign CHNL_TX_LEN        = ((r_state == c_st_turn) || w_in_tx) ? w_tx_len : '0;
    assign CHNL_TX_DATA_VALID = w_tx_valid;
    assign CHNL_TX_DATA       = !w_tx_valid ? '0 :
                                r_mode      ? w_pattern : w_fifo_data;
    assign CNT_ERR            = r_cnt_err;

    // Channel fields this loopback has no use for.
    logic w_unused_bits;
    assign w_unused_bits = ^{CHNL_RX_LAST, CHNL_RX_OFF, CHNL_TX_ACK, w_len_rnd[33:32]};

endmodule
`default_nettype wire

// File: tb/tb_iob_pcie_loopback.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_pcie_loopback
// Description : Self-checking bench for iob_pcie_loopback. Two instances:
//               u_a (DATA_W=32, ADDR_W=2, four-beat buffer) and
//               u_b (DATA_W=64, ADDR_W=9). A transfer-level model predicts
//               the TX length, beat stream and overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_pcie_loopback;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus
    logic        rst, mode, rx_a, rx_b, rx_valid, tx_ren, tx_ack, sel;
    logic [31:0] rx_len;
    logic [63:0] rx_data;

    // instance a outputs
    logic        a_rxclk, a_ack, a_rren, a_txclk, a_tx, a_last, a_valid, a_err;
    logic [31:0] a_txlen, a_data;
    logic [30:0] a_off;
    // instance b outputs
    logic        b_rxclk, b_ack, b_rren, b_txclk, b_tx, b_last, b_valid, b_err;
    logic [31:0] b_txlen;
    logic [63:0] b_data;
    logic [30:0] b_off;

    iob_pcie_loopback #(.DATA_W(32), .ADDR_W(2)) u_a (
        .CLK(clk), .RST(rst), .MODE(mode), .CNT_ERR(a_err),
        .CHNL_RX_CLK(a_rxclk), .CHNL_RX(rx_a), .CHNL_RX_ACK(a_ack),
        .CHNL_RX_LAST(1'b1), .CHNL_RX_LEN(rx_len), .CHNL_RX_OFF(31'd0),
        .CHNL_RX_DATA(rx_data[31:0]), .CHNL_RX_DATA_VALID(rx_valid),
        .CHNL_RX_DATA_REN(a_rren),
        .CHNL_TX_CLK(a_txclk), .CHNL_TX(a_tx), .CHNL_TX_ACK(tx_ack),
        .CHNL_TX_LAST(a_last), .CHNL_TX_LEN(a_txlen), .CHNL_TX_OFF(a_off),
        .CHNL_TX_DATA(a_data), .CHNL_TX_DATA_VALID(a_valid),
        .CHNL_TX_DATA_REN(tx_ren)
    );

    iob_pcie_loopback #(.DATA_W(64), .ADDR_W(9)) u_b (
        .CLK(clk), .RST(rst), .MODE(mode), .CNT_ERR(b_err),
        .CHNL_RX_CLK(b_rxclk), .CHNL_RX(rx_b), .CHNL_RX_ACK(b_ack),
        .CHNL_RX_LAST(1'b1), .CHNL_RX_LEN(rx_len), .CHNL_RX_OFF(31'd0),
        .CHNL_RX_DATA(rx_data), .CHNL_RX_DATA_VALID(rx_valid),
        .CHNL_RX_DATA_REN(b_rren),
        .CHNL_TX_CLK(b_txclk), .CHNL_TX(b_tx), .CHNL_TX_ACK(tx_ack),
        .CHNL_TX_LAST(b_last), .CHNL_TX_LEN(b_txlen), .CHNL_TX_OFF(b_off),
        .CHNL_TX_DATA(b_data), .CHNL_TX_DATA_VALID(b_valid),
        .CHNL_TX_DATA_REN(tx_ren)
    );

    // outputs of the instance under test
    logic        s_ack, s_rren, s_tx, s_valid, s_err, s_last;
    logic [31:0] s_txlen;
    logic [30:0] s_off;
    logic [63:0] s_data;

    always_comb begin
        if (sel) begin
            s_ack = b_ack; s_rren = b_rren; s_tx = b_tx; s_valid = b_valid;
            s_err = b_err; s_last = b_last; s_txlen = b_txlen; s_off = b_off;
            s_data = b_data;
        end else begin
            s_ack = a_ack; s_rren = a_rren; s_tx = a_tx; s_valid = a_valid;
            s_err = a_err; s_last = a_last; s_txlen = a_txlen; s_off = a_off;
            s_data = {32'd0, a_data};
        end
    end

    // model state
    logic [31:0] src[$];
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];
    logic [31:0] exp_len;
    logic        exp_err;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_obs(input int idx, input logic [63:0] exp);
        logic [63:0] got;
        got = (idx < obs_q.size()) ? obs_q[idx] : 64'hx;
        chk($sformatf("obs_beat%0d", idx), got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack();
        for (int t = 0; t < 20 && !s_ack; t++) tick();
        chk("rx_ack", {s_ack, s_rren}, 2'b11);
    endtask

    // Every TX cycle is checked against the model's beat queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (s_tx) begin
                chk("tx_active", 64'(s_tx), 64'(exp_q.size() != 0));
                chk("tx_len", 64'(s_txlen), 64'(exp_len));
                chk("tx_last_off", {32'd0, s_last, s_off}, {32'd0, 1'b1, 31'd0});
            end
            if (s_valid && tx_ren) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_extra_beat: got 0x%0h, expected no beat", s_data);
                end else begin
                    chk("tx_beat", s_data, exp_q.pop_front());
                    obs_q.push_back(s_data);
                end
            end
        end
    end

    // One complete loopback transfer: predict, drive RX, drain TX.
    task automatic run_xfer(input bit s, input bit m, input int len, input bit toggle);
        int w, d, nb, cap, txl, t;
        logic [63:0] beat;
        w   = s ? 2 : 1;
        d   = s ? 512 : 4;
        nb  = (len + w - 1) / w;
        cap = (len < w * d) ? len : w * d;
        txl = ((cap + w - 1) / w) * w;
        exp_len = 32'(txl);
        exp_err = (nb > d);
        obs_q.delete();
        for (int k = 0; k < txl / w; k++) begin
            beat = '0;
            for (int j = 0; j < w; j++)
                beat[j*32 +: 32] = m ? 32'(k * w + j + 1) : src[k * w + j];
            exp_q.push_back(beat);
        end

        sel = s; mode = m; rx_len = 32'(len);
        if (s) rx_b = 1'b1; else rx_a = 1'b1;
        wait_ack();
        for (int k = 0; k < nb; k++) begin
            rx_data = '0;
            for (int j = 0; j < w; j++) rx_data[j*32 +: 32] = src[k * w + j];
            rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0; rx_a = 1'b0; rx_b = 1'b0;

        t = 0;
        while ((exp_q.size() != 0 || s_tx) && t < 400) begin
            if (toggle) tx_ren = ~tx_ren;
            tick();
            t++;
        end
        if (t >= 400) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_timeout: %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        tx_ren = 1'b1;
        tick();
        tick();
        chk("cnt_err", 64'(s_err), 64'(exp_err));
        chk("back_idle", {s_tx, s_ack, s_valid}, 3'b000);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mode = 1'b0; rx_a = 1'b0; rx_b = 1'b0; rx_valid = 1'b0;
        tx_ren = 1'b1; tx_ack = 1'b0; rx_len = '0; rx_data = '0; sel = 1'b0;
        exp_len = '0; exp_err = 1'b0;
        repeat (3) tick();

        // reset state of both instances
        chk("rst_a_ctrl", {a_ack, a_rren, a_tx, a_valid, a_err}, 5'b0);
        chk("rst_a_len_data", {a_txlen, a_data}, 64'd0);
        chk("rst_b_ctrl", {b_ack, b_rren, b_tx, b_valid, b_err}, 5'b0);
        chk("rst_b_len_data", {32'd0, b_txlen} | b_data, 64'd0);
        @(negedge clk);
        chk("clk_fwd", {a_rxclk, a_txclk, b_rxclk, b_txclk}, 4'b0000);
        rst = 1'b0;
        tick();

        // 32-bit echo of four words
        src = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        run_xfer(0, 0, 4, 0);
        chk("echo4_count", 64'(obs_q.size()), 64'd4);
        chk_obs(0, 64'hAAAA_0001);
        chk_obs(3, 64'hDDDD_0004);
        chk("echo4_err", 64'(s_err), 64'd0);

        // 64-bit counter pattern, six words
        src = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
        run_xfer(1, 1, 6, 0);
        chk_obs(0, 64'h00000002_00000001);
        chk_obs(1, 64'h00000004_00000003);
        chk_obs(2, 64'h00000006_00000005);

        // overflow of the four-entry buffer
        src = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106};
        run_xfer(0, 0, 6, 0);
        chk("ovf_count", 64'(obs_q.size()), 64'd4);
        chk_obs(3, 64'h104);
        chk("ovf_err", 64'(s_err), 64'd1);

        // receiver throttling on alternate cycles
        src = '{32'h201, 32'h202, 32'h203, 32'h204};
        run_xfer(0, 0, 4, 1);
        chk("thr_count", 64'(obs_q.size()), 64'd4);
        chk_obs(0, 64'h201);
        chk_obs(1, 64'h202);
        chk_obs(2, 64'h203);
        chk_obs(3, 64'h204);
        chk("thr_err_cleared", 64'(s_err), 64'd0);

        // pattern on 32-bit, odd length echo on 64-bit
        run_xfer(0, 1, 3, 0);
        chk_obs(2, 64'd3);
        src = '{32'h301, 32'h302, 32'h303, 32'h304, 32'h305, 32'h306};
        run_xfer(1, 0, 5, 1);
        chk_obs(2, 64'h00000306_00000305);

        // reset two beats into an eight-word receive
        src = '{32'h401, 32'h402};
        sel = 1'b0; mode = 1'b0; rx_len = 32'd8; rx_a = 1'b1;
        wait_ack();
        for (int k = 0; k < 2; k++) begin
            rx_data = 64'(src[k]);
            rx_valid = 1'b1;
            tick();
        end
        rst = 1'b1;
        rx_valid = 1'b0;
        tick();
        chk("mid_rst_ctrl", {a_ack, a_rren, a_tx, a_valid, a_err}, 5'b0);
        chk("mid_rst_len_data", {a_txlen, a_data}, 64'd0);
        rst = 1'b0;
        rx_a = 1'b0;
        tick();
        src = '{32'h501, 32'h502};
        run_xfer(0, 0, 2, 0);
        chk("post_rst_count", 64'(obs_q.size()), 64'd2);
        chk_obs(0, 64'h501);
        chk_obs(1, 64'h502);

        // zero-length transfers
        run_xfer(0, 0, 0, 0);
        run_xfer(1, 1, 0, 0);
        chk("len0_count", 64'(obs_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
